// File: rtl/mem_serdes_pkg.sv
// Shared types and constants for the memory/ALU serial bridge.
package mem_serdes_pkg;

  localparam int REG_BITS     = 8;
  localparam int NSHIFT       = 2;
  localparam int WORD_BITS    = 2 * REG_BITS;
  localparam int MSD_CNT_BITS = 4;

  // A full pair op shifts one word through in WORD_BITS/NSHIFT cycles.
  localparam logic [MSD_CNT_BITS-1:0] MSD_MAX_CNT = MSD_CNT_BITS'(WORD_BITS / NSHIFT);

  typedef enum logic [1:0] {
    MSD_EMPTY      = 2'd0,
    MSD_LOADED     = 2'd1,
    MSD_SHIFTING   = 2'd2,
    MSD_STORE_PEND = 2'd3
  } msd_state_e;

endpackage

// File: rtl/mem_serdes_if.sv
// Read/write beat bus between the operand memory side and mem_serdes.
interface mem_serdes_if;
  import mem_serdes_pkg::*;

  logic                 rd_valid;
  logic                 rd_ready;
  logic [WORD_BITS-1:0] rd_data;
  logic                 rd_pair;
  logic                 rd_store;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [WORD_BITS-1:0] wr_data;

  // Bridge side: consumes read beats, produces write beats.
  modport slave (
    input  rd_valid, rd_data, rd_pair, rd_store, wr_ready,
    output rd_ready, wr_valid, wr_data
  );

  // Memory side: offers read beats, accepts write beats.
  modport master (
    output rd_valid, rd_data, rd_pair, rd_store, wr_ready,
    input  rd_ready, wr_valid, wr_data
  );

endinterface

// File: rtl/mem_serdes_align.sv
// Realigns a captured serial result: the first shifted-in bit pair lands at
// bit 0 by shifting right by the number of bits never shifted in.
module mem_serdes_align
  import mem_serdes_pkg::*;
(
  input  logic [WORD_BITS-1:0]    din,
  input  logic [MSD_CNT_BITS-1:0] cnt,
  output logic [WORD_BITS-1:0]    dout
);

  logic [MSD_CNT_BITS:0] shamt;

  // Two bits enter per cycle, so the unused span is WORD_BITS - 2*cnt.
  always_comb begin
    shamt = (MSD_CNT_BITS + 1)'(WORD_BITS) - {cnt, 1'b0};
    dout  = din >> shamt;
  end

endmodule

// File: rtl/mem_serdes.sv
// Word-to-serial bridge: shifts a read beat into the ALU LSB-first and reuses
// the same shift register to capture the ALU's serial result for write-back.
module mem_serdes
  import mem_serdes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_serdes_if.slave       bus,
  input  logic              alu_active,
  input  logic              alu_op_done,
  input  logic [NSHIFT-1:0] alu_data_out,
  output logic [NSHIFT-1:0] data_in,
  output logic              busy
);

  msd_state_e                state_q, state_d;
  logic [WORD_BITS-1:0]      sreg_q, sreg_d;
  logic [WORD_BITS-1:0]      sreg_shift;
  logic [WORD_BITS-1:0]      wr_data_q, wr_data_d;
  logic [WORD_BITS-1:0]      align_out;
  logic [MSD_CNT_BITS-1:0]   n_q, n_d, n_inc;
  logic                      store_q, store_d;
  logic                      pair_q, pair_d;
  logic                      in_op;

  assign in_op      = (state_q == MSD_LOADED) || (state_q == MSD_SHIFTING);
  assign sreg_shift = {alu_data_out, sreg_q[WORD_BITS-1:NSHIFT]};
  assign n_inc      = (n_q >= MSD_MAX_CNT) ? MSD_MAX_CNT : n_q + 1'b1;

  // Alignment sees this cycle's shift and count so the final pair is included.
  mem_serdes_align u_align (
    .din  (sreg_shift),
    .cnt  (n_inc),
    .dout (align_out)
  );

  assign data_in      = in_op ? sreg_q[NSHIFT-1:0] : '0;
  assign busy         = (state_q != MSD_EMPTY);
  assign bus.rd_ready = (state_q == MSD_EMPTY);
  assign bus.wr_valid = (state_q == MSD_STORE_PEND);
  assign bus.wr_data  = wr_data_q;

  // Next-state and datapath update; active cycles outside an op are ignored.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    n_d       = n_q;
    store_d   = store_q;
    pair_d    = pair_q;
    wr_data_d = wr_data_q;
    case (state_q)
      MSD_EMPTY: begin
        if (bus.rd_valid) begin
          sreg_d  = bus.rd_data;
          pair_d  = bus.rd_pair;
          store_d = bus.rd_store;
          n_d     = '0;
          state_d = MSD_LOADED;
        end
      end
      MSD_LOADED, MSD_SHIFTING: begin
        if (alu_active) begin
          sreg_d = sreg_shift;
          n_d    = n_inc;
          if (alu_op_done) begin
            if (store_q) begin
              wr_data_d = align_out;
              state_d   = MSD_STORE_PEND;
            end else begin
              state_d   = MSD_EMPTY;
            end
          end else begin
            state_d = MSD_SHIFTING;
          end
        end
      end
      MSD_STORE_PEND: begin
        if (bus.wr_ready) state_d = MSD_EMPTY;
      end
      default: state_d = MSD_EMPTY;
    endcase
  end

  // State and datapath registers; reset discards any captured result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MSD_EMPTY;
      sreg_q    <= '0;
      n_q       <= '0;
      store_q   <= 1'b0;
      pair_q    <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      n_q       <= n_d;
      store_q   <= store_d;
      pair_q    <= pair_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
